serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial ripple-borrow subtractor: computes diff = a - b - bin, LSB first, one bit per clock through a single full-subtractor cell.
- Sequential counterpart to the combinational ripple-carry adder. It provides the subtract direction, using a small area of one cell plus shift registers.
- Uses a valid/ready handshake on both the operand and result sides, so it can sit between producer and consumer stages in the datapath.

Parameters:
WIDTH, 4, operand/result width in bits (legal range >= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands a, b, bin valid
in_ready  output  1  block accepts operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in
out_valid  output  1  diff/bout valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow out (1 when a < b + bin, unsigned)
zero  output  1  present only with SERIAL_SUB_FLAGS_EN; diff == 0
ovf  output  1  present only with SERIAL_SUB_FLAGS_EN; two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, zero=0, ovf=0, all internal shift registers, counter and borrow = 0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b into shift registers and bin into the borrow register. Clear count. Go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - d = a0^b0^br
    - br' = (~a0&b0) | (~(a0^b0)&br)
    - Shift a and b right by 1; shift d into the result MSB (result shifts right).
    - count++. When count reaches WIDTH-1 on this edge, go to DONE.
  - DONE: out_valid=1. diff = result register, bout = final borrow. Both are held stable while out_ready=0. On out_valid&&out_ready, go to IDLE.
- Latency: operands accepted at edge N produce out_valid high after edge N+WIDTH (exactly WIDTH RUN cycles).
- Throughput: one operation per WIDTH+2 cycles minimum. DONE->IDLE costs one cycle, and in_ready is not combinationally tied to out_ready.
- Counter width is $clog2(WIDTH+1). WIDTH=1 gives a single RUN cycle.
- in_valid and a/b/bin are ignored outside IDLE. Operand changes after acceptance do not affect the result.
- out_ready is ignored outside DONE.
- diff/bout are held between transactions: they update only on the RUN->DONE transition and retain their value in IDLE.
- Arithmetic: unsigned modulo 2^WIDTH. bout equals the borrow out of the MSB cell.
- Asynchronous reset mid-RUN or mid-DONE:
  - The in-flight result is discarded and all outputs take reset values immediately.
  - in_ready=1 in the first cycle after rst_n deasserts.

Optional Feature:
- Macro SERIAL_SUB_FLAGS_EN.
- Defined:
  - Ports zero and ovf exist, registered on the RUN->DONE transition alongside diff.
  - zero = (diff == 0).
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using a_msb and b_msb captured at acceptance.
  - Both reset to 0.
- Undefined: ports and capture registers are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package serial_sub_pkg holds:
  - state enum {IDLE, RUN, DONE} with 2-bit encoding 00/01/10
  - function for counter width
- Sub-module fs: combinational 1-bit full subtractor (a, b, bin -> d, bout), instantiated once in the datapath.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0 -> diff=6, bout=0. out_valid rises exactly 4 cycles after the accept edge.
- a=3, b=9, bin=0 -> diff=0xA, bout=1.
- a=0, b=0, bin=1 -> diff=0xF, bout=1.
- Back-pressure: out_ready held low 5 cycles in DONE -> diff/bout stable, in_ready=0 throughout. A new in_valid in that window is not accepted. After the out_ready handshake, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 two cycles into RUN -> out_valid=0, diff=0, in_ready=1 immediately. A fresh a=7, b=2 then yields diff=5, bout=0.
- Flags, with SERIAL_SUB_FLAGS_EN:
  - a=8, b=1 -> diff=7, ovf=1, zero=0.
  - a=5, b=5 -> diff=0, zero=1, ovf=0, bout=0.
  - Flags macro undefined -> the build contains no zero/ovf ports.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bits needed for a count that reaches WIDTH-1 (and never below one bit).
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// zero/ovf exist only when SERIAL_SUB_FLAGS_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  // valid/ready: a transfer happens on a rising clk edge where valid && ready;
  // the source holds its payload stable while valid is high and ready is low.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_FLAGS_EN
    input  zero, ovf,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_FLAGS_EN
    output zero, ovf,
`endif
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module serial_subtractor_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor, LSB first, one full-subtractor cell.
// Optional zero/ovf flags are built when SERIAL_SUB_FLAGS_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus,
  output state_t              dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ar_q;
  logic [WIDTH-1:0] ar_next;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             d;
  logic             bo;
  logic             last;
  logic             accept;

  serial_subtractor_fs u_fs (
    .a    (ar_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d),
    .bout (bo)
  );

  // The minuend register doubles as the result register: each consumed
  // minuend bit frees the MSB slot that the new difference bit fills.
  if (WIDTH == 1) begin : g_w1
    assign ar_next = d;
  end else begin : g_wn
    assign ar_next = {d, ar_q[WIDTH-1:1]};
  end

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (last)         state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q   <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      ar_q  <= bus.a;
      b_q   <= bus.b;
      br_q  <= bus.bin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      ar_q  <= ar_next;
      b_q   <= b_q >> 1;
      br_q  <= bo;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        diff_q <= ar_next;
        bout_q <= bo;
      end
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb_q, b_msb_q, zero_q, ovf_q;

  // Operand sign bits are captured at acceptance because the shift
  // registers no longer hold them by the end of the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
    end else if (last) begin
      zero_q <= (ar_next == '0);
      ovf_q  <= (a_msb_q != b_msb_q) && (ar_next[WIDTH-1] != a_msb_q);
    end
  end

  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`endif

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4); flag checks are
// compiled in when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 4;
`ifdef SERIAL_SUB_FLAGS_EN
  localparam int EW = W + 3;
`else
  localparam int EW = W + 1;
`endif

  logic   clk;
  logic   rst_n;
  state_t dbg_state;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_done;
  int            n_vec;
  int            n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: straight integer arithmetic on the operands.
  function automatic logic [EW-1:0] model(input int a, input int b, input int bin);
    int         r;
    logic [W-1:0] dv;
    logic       bo;
    r  = a - b - bin;
    dv = r[W-1:0];
    bo = (r < 0);
`ifdef SERIAL_SUB_FLAGS_EN
    return {((a >> (W-1)) & 1) != ((b >> (W-1)) & 1) && (dv[W-1] != ((a >> (W-1)) & 1)),
            (dv == '0), bo, dv};
`else
    return {bo, dv};
`endif
  endfunction

  function automatic logic [EW-1:0] observed();
`ifdef SERIAL_SUB_FLAGS_EN
    return {bus.ovf, bus.zero, bus.bout, bus.diff};
`else
    return {bus.bout, bus.diff};
`endif
  endfunction

  // Compare process: result checked every cycle it is presented, held value
  // checked every idle cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_valid_exclusive", {31'd0, bus.in_ready & bus.out_valid}, 32'd0);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_result");
        end else begin
          chk("result", 32'(observed()), 32'(exp_q[0]));
          if (bus.out_ready) last_done = exp_q.pop_front();
        end
      end else if (bus.in_ready) begin
        chk("idle_hold", 32'(observed()), 32'(last_done));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) timeout("send");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom_range(0, 15);
    bus.b = $urandom_range(0, 15);
    bus.bin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 50) timeout("wait_valid");
  endtask

  // Full transaction with hand-computed expectations pinning the model.
  task automatic run_op(input int a, input int b, input int bin,
                        input int exp_diff, input int exp_bout);
    logic [EW-1:0] m;
    int            lat;
    m = model(a, b, bin);
    chk("model_diff", 32'(m[W-1:0]), 32'(exp_diff));
    chk("model_bout", 32'(m[W]), 32'(exp_bout));
    exp_q.push_back(m);
    send(W'(a), W'(b), 1'(bin));
    wait_valid(lat);
    chk("latency", 32'(lat), 32'(W));
    chk("diff_literal", 32'(bus.diff), 32'(exp_diff));
    chk("bout_literal", 32'(bus.bout), 32'(exp_bout));
    @(posedge clk); #1;
    chk("ready_after_done", {31'd0, bus.in_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    n_vec = 0;
    n_err = 0;
    last_done = '0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", {31'd0, bus.bout}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    run_op(9, 3, 0, 6, 0);
    run_op(3, 9, 0, 10, 1);
    run_op(0, 0, 1, 15, 1);
    run_op(15, 15, 1, 15, 1);
    run_op(15, 0, 0, 15, 0);
    run_op(0, 15, 0, 1, 1);
    run_op(8, 8, 0, 0, 0);
    run_op(12, 5, 1, 6, 0);

    // Back-pressure: result held, no new acceptance, then release.
    bus.out_ready = 1'b0;
    exp_q.push_back(model(13, 6, 1));
    send(4'd13, 4'd6, 1'b1);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'(W));
    bus.in_valid = 1'b1;
    bus.a = 4'd1;
    bus.b = 4'd1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_diff", 32'(bus.diff), 32'd6);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset two cycles into RUN.
    send(4'd12, 4'd3, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_diff", 32'(bus.diff), 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    last_done = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    run_op(7, 2, 0, 5, 0);

`ifdef SERIAL_SUB_FLAGS_EN
    run_op(8, 1, 0, 7, 0);
    chk("flag_ovf_8_1", {31'd0, last_done[W+2]}, 32'd1);
    chk("flag_zero_8_1", {31'd0, last_done[W+1]}, 32'd0);
    run_op(5, 5, 0, 0, 0);
    chk("flag_zero_5_5", {31'd0, last_done[W+1]}, 32'd1);
    chk("flag_ovf_5_5", {31'd0, last_done[W+2]}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
